game_controller_mp: RTL and testbench

Parametrised successor to the word-scramble game controller. It sequences one player session: login, mode setup, timed play, game over, logout, and a leaderboard view. It generalises to NUM_MODES difficulty modes, a configurable score width, and a strike limit that ends the game early. It also keeps one best-score register per mode, and guest players never update those registers. It sits between the input debouncers/keypad decoder and the display mux, letter scrambler and round timer.

---
 rtl/game_controller_mp_if.sv | 55 +++++
 rtl/game_controller_mp.sv | 181 ++++++++++++++++++
 tb/tb_game_controller_mp.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_controller_mp_if.sv
// Signal bundle between the input decoders/timer and game_controller_mp.
// The controller takes the slave view; the driving side takes the master view.
interface game_controller_mp_if #(
    parameter int unsigned NUM_MODES = 4,
    parameter int unsigned SCORE_W   = 7,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned PID_W     = 3
);
    localparam int unsigned MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;

    logic               log_on;
    logic               pwd_pls;
    logic               start_pls;
    logic               load_pls;
    logic [PID_W-1:0]   pid_in;
    logic               is_guest_in;
    logic [IDX_W-1:0]   idx_in1;
    logic [IDX_W-1:0]   idx_in2;
    logic               ans_vld;
    logic               is_correct;
    logic               time_out;

    logic [2:0]         ctrl_sig;
    logic               log_out;
    logic [PID_W-1:0]   pid_out;
    logic               is_guest_out;
    logic [SCORE_W-1:0] score;
    logic [1:0]         strikes;
    logic [MODE_W-1:0]  lett_num;
    logic [3:0]         mode_disp;
    logic               scram_pls;
    logic               flip_pls;
    logic [IDX_W-1:0]   idx_out1;
    logic [IDX_W-1:0]   idx_out2;
    logic               timer_en;
    logic               timer_reconfig;
    logic [SCORE_W-1:0] best_score;
    logic               new_best;

    modport master (
        output log_on, pwd_pls, start_pls, load_pls, pid_in, is_guest_in,
               idx_in1, idx_in2, ans_vld, is_correct, time_out,
        input  ctrl_sig, log_out, pid_out, is_guest_out, score, strikes, lett_num,
               mode_disp, scram_pls, flip_pls, idx_out1, idx_out2, timer_en,
               timer_reconfig, best_score, new_best
    );

    modport slave (
        input  log_on, pwd_pls, start_pls, load_pls, pid_in, is_guest_in,
               idx_in1, idx_in2, ans_vld, is_correct, time_out,
        output ctrl_sig, log_out, pid_out, is_guest_out, score, strikes, lett_num,
               mode_disp, scram_pls, flip_pls, idx_out1, idx_out2, timer_en,
               timer_reconfig, best_score, new_best
    );
endinterface

// File: rtl/game_controller_mp.sv
// Session sequencer for the word-scramble game: login, mode setup, timed play,
// game over, logout and leaderboard, with a per-mode best-score table.
module game_controller_mp #(
    parameter int unsigned NUM_MODES   = 4,
    parameter int unsigned SCORE_W     = 7,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned PID_W       = 3,
    parameter int unsigned MAX_STRIKES = 3,
    parameter int unsigned DISP_BASE   = 4
) (
    input logic                 clk,
    input logic                 rst,
    game_controller_mp_if.slave bus
);
    localparam int unsigned MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
    localparam logic [MODE_W-1:0] LastMode = MODE_W'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StPlay   = 3'd2,
        StOver   = 3'd3,
        StBoard  = 3'd4,
        StLogout = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [MODE_W-1:0]  mode_q, mode_d, page_q, page_d, lett_num_q, lett_num_d;
    logic [SCORE_W-1:0] score_q, score_d, score_upd, best_score_q, best_score_d;
    logic [SCORE_W-1:0] best_q [NUM_MODES];
    logic [SCORE_W-1:0] best_d [NUM_MODES];
    logic [1:0]         strikes_q, strikes_d, strikes_upd;
    logic [IDX_W-1:0]   idx1_q, idx1_d, idx2_q, idx2_d;
    logic [PID_W-1:0]   pid_q, pid_d;
    logic [2:0]         ctrl_sig_q, ctrl_sig_d;
    logic [3:0]         mode_disp_q, mode_disp_d;
    logic guest_q, guest_d, new_best_q, new_best_d, scram_q, scram_d, flip_q, flip_d;
    logic log_out_q, log_out_d, timer_en_q, timer_en_d, timer_reconfig_q, timer_reconfig_d;
    logic play_end;

    // Answer accounting happens before the end test, so a final answer still counts.
    always_comb begin
        score_upd   = score_q;
        strikes_upd = strikes_q;
        if (bus.ans_vld && bus.is_correct && score_q != '1) score_upd = score_q + SCORE_W'(1);
        if (bus.ans_vld && !bus.is_correct && strikes_q != 2'd3) strikes_upd = strikes_q + 2'd1;
        play_end = bus.time_out || (MAX_STRIKES != 0 && 32'(strikes_upd) == MAX_STRIKES);
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.log_on) state_d = StSetup;
            StSetup: begin
                if (bus.pwd_pls)                              state_d = StLogout;
                else if (bus.load_pls && mode_q == LastMode)  state_d = StBoard;
                else if (!bus.load_pls && bus.start_pls)      state_d = StPlay;
            end
            StPlay:   if (play_end) state_d = StOver;
            StOver:   if (bus.start_pls) state_d = StIdle;
            StLogout: state_d = StIdle;
            StBoard:  if (bus.load_pls) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d     = mode_q;
        page_d     = page_q;
        score_d    = score_q;
        strikes_d  = strikes_q;
        new_best_d = new_best_q;
        lett_num_d = lett_num_q;
        idx1_d     = idx1_q;
        idx2_d     = idx2_q;
        pid_d      = pid_q;
        guest_d    = guest_q;
        best_d     = best_q;
        scram_d    = 1'b0;
        flip_d     = 1'b0;
        case (state_q)
            StIdle: mode_d = '0;
            StSetup: begin
                if (!bus.pwd_pls && bus.load_pls) begin
                    if (mode_q == LastMode) begin
                        mode_d = '0;
                        page_d = '0;
                    end else begin
                        mode_d = mode_q + MODE_W'(1);
                    end
                end else if (!bus.pwd_pls && bus.start_pls) begin
                    lett_num_d = mode_q;
                end
            end
            StPlay: begin
                scram_d    = bus.start_pls;
                flip_d     = bus.load_pls;
                idx1_d     = bus.idx_in1;
                idx2_d     = bus.idx_in2;
                lett_num_d = mode_q;
                score_d    = score_upd;
                strikes_d  = strikes_upd;
                if (play_end && !bus.is_guest_in && score_upd > best_q[mode_q]) begin
                    best_d[mode_q] = score_upd;
                    new_best_d     = 1'b1;
                end
            end
            StOver: begin
                pid_d   = bus.pid_in;
                guest_d = bus.is_guest_in;
            end
            StBoard: begin
                if (!bus.load_pls && bus.start_pls) begin
                    page_d = (page_q == LastMode) ? '0 : page_q + MODE_W'(1);
                end
            end
            default: ;
        endcase
        if (state_d == StSetup) begin
            score_d    = '0;
            strikes_d  = '0;
            new_best_d = 1'b0;
        end

        // Display-facing outputs follow the state being entered so they are registered.
        log_out_d        = (state_d == StLogout);
        timer_en_d       = (state_d == StPlay);
        timer_reconfig_d = (state_d == StIdle);
        best_score_d     = (state_d == StBoard) ? best_d[page_d] : best_d[mode_d];
        case (state_d)
            StSetup: begin ctrl_sig_d = 3'd1; mode_disp_d = 4'(mode_d) + 4'(DISP_BASE); end
            StPlay:  begin ctrl_sig_d = 3'd2; mode_disp_d = 4'(mode_d) + 4'(DISP_BASE); end
            StOver:  begin ctrl_sig_d = 3'd3; mode_disp_d = 4'(mode_d) + 4'(DISP_BASE); end
            StBoard: begin ctrl_sig_d = 3'd4; mode_disp_d = 4'(page_d); end
            default: begin ctrl_sig_d = 3'd0; mode_disp_d = 4'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= '0;  page_q <= '0;  lett_num_q <= '0;
            score_q <= '0; strikes_q <= '0; new_best_q <= 1'b0;
            idx1_q <= '0;  idx2_q <= '0;  pid_q <= '0;  guest_q <= 1'b0;
            scram_q <= 1'b0; flip_q <= 1'b0; log_out_q <= 1'b0;
            timer_en_q <= 1'b0; timer_reconfig_q <= 1'b1;
            ctrl_sig_q <= '0; mode_disp_q <= '0; best_score_q <= '0;
            for (int i = 0; i < int'(NUM_MODES); i++) best_q[i] <= '0;
        end else begin
            mode_q <= mode_d;  page_q <= page_d;  lett_num_q <= lett_num_d;
            score_q <= score_d; strikes_q <= strikes_d; new_best_q <= new_best_d;
            idx1_q <= idx1_d;  idx2_q <= idx2_d;  pid_q <= pid_d;  guest_q <= guest_d;
            scram_q <= scram_d; flip_q <= flip_d; log_out_q <= log_out_d;
            timer_en_q <= timer_en_d; timer_reconfig_q <= timer_reconfig_d;
            ctrl_sig_q <= ctrl_sig_d; mode_disp_q <= mode_disp_d; best_score_q <= best_score_d;
            best_q <= best_d;
        end
    end

    assign bus.ctrl_sig       = ctrl_sig_q;
    assign bus.log_out        = log_out_q;
    assign bus.pid_out        = pid_q;
    assign bus.is_guest_out   = guest_q;
    assign bus.score          = score_q;
    assign bus.strikes        = strikes_q;
    assign bus.lett_num       = lett_num_q;
    assign bus.mode_disp      = mode_disp_q;
    assign bus.scram_pls      = scram_q;
    assign bus.flip_pls       = flip_q;
    assign bus.idx_out1       = idx1_q;
    assign bus.idx_out2       = idx2_q;
    assign bus.timer_en       = timer_en_q;
    assign bus.timer_reconfig = timer_reconfig_q;
    assign bus.best_score     = best_score_q;
    assign bus.new_best       = new_best_q;
endmodule

// File: tb/tb_game_controller_mp.sv
// Scoreboard bench for game_controller_mp: a session-level model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_game_controller_mp;
    localparam int NM = 4;
    localparam int SMAX = 127;
    localparam int MAXS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_controller_mp_if #(.NUM_MODES(NM), .SCORE_W(7), .IDX_W(3), .PID_W(3)) bus ();

    game_controller_mp #(
        .NUM_MODES(NM), .SCORE_W(7), .IDX_W(3), .PID_W(3), .MAX_STRIKES(MAXS), .DISP_BASE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Phase codes: 0 idle, 1 setup, 2 play, 3 over, 4 board, 5 logout
    typedef struct {
        int phase; int ctrl; int log_out; int score; int strikes; int lett; int mdisp;
        int scram; int flip; int idx1; int idx2; int ten; int trc; int best; int nb;
        int pid; int guest;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    int m_phase, m_mode, m_page, m_score, m_strikes, m_lett, m_scram, m_flip;
    int m_idx1, m_idx2, m_nb, m_pid, m_guest;
    int m_best [NM];

    task automatic model_step();
        int prev;
        if (!rst) begin
            m_phase = 0; m_mode = 0; m_page = 0; m_score = 0; m_strikes = 0; m_lett = 0;
            m_scram = 0; m_flip = 0; m_idx1 = 0; m_idx2 = 0; m_nb = 0; m_pid = 0; m_guest = 0;
            for (int i = 0; i < NM; i++) m_best[i] = 0;
            return;
        end
        prev    = m_phase;
        m_scram = (prev == 2 && bus.start_pls) ? 1 : 0;
        m_flip  = (prev == 2 && bus.load_pls) ? 1 : 0;
        if (prev == 2) begin m_idx1 = int'(bus.idx_in1); m_idx2 = int'(bus.idx_in2); end
        if (prev == 3) begin m_pid = int'(bus.pid_in); m_guest = int'(bus.is_guest_in); end
        case (prev)
            0: begin
                m_mode = 0;
                if (bus.log_on) begin m_phase = 1; m_score = 0; m_strikes = 0; m_nb = 0; end
            end
            1: begin
                if (bus.pwd_pls) m_phase = 5;
                else if (bus.load_pls) begin
                    if (m_mode == NM - 1) begin m_mode = 0; m_page = 0; m_phase = 4; end
                    else m_mode = m_mode + 1;
                end else if (bus.start_pls) begin m_lett = m_mode; m_phase = 2; end
            end
            2: begin
                m_lett = m_mode;
                if (bus.ans_vld && bus.is_correct && m_score < SMAX) m_score++;
                if (bus.ans_vld && !bus.is_correct && m_strikes < 3) m_strikes++;
                if (bus.time_out || (MAXS != 0 && m_strikes == MAXS)) begin
                    m_phase = 3;
                    if (!bus.is_guest_in && m_score > m_best[m_mode]) begin
                        m_best[m_mode] = m_score;
                        m_nb = 1;
                    end
                end
            end
            3: if (bus.start_pls) m_phase = 0;
            4: begin
                if (bus.load_pls) m_phase = 0;
                else if (bus.start_pls) m_page = (m_page + 1) % NM;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.phase = m_phase;     e.ctrl = (m_phase == 5) ? 0 : m_phase;
        e.log_out = (m_phase == 5) ? 1 : 0;
        e.score = m_score;     e.strikes = m_strikes; e.lett = m_lett;
        e.mdisp = (m_phase == 4) ? m_page : m_mode + 4;
        e.scram = m_scram;     e.flip = m_flip;   e.idx1 = m_idx1; e.idx2 = m_idx2;
        e.ten = (m_phase == 2) ? 1 : 0;  e.trc = (m_phase == 0) ? 1 : 0;
        e.best = (m_phase == 4) ? m_best[m_page] : m_best[m_mode];
        e.nb = m_nb;           e.pid = m_pid;     e.guest = m_guest;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        push_exp();
    endtask

    task automatic drive(input bit lo, input bit pwd, input bit st, input bit ld,
                         input bit av, input bit ic, input bit to);
        bus.log_on = lo; bus.pwd_pls = pwd; bus.start_pls = st; bus.load_pls = ld;
        bus.ans_vld = av; bus.is_correct = ic; bus.time_out = to;
        tick();
        bus.log_on = 0; bus.pwd_pls = 0; bus.start_pls = 0; bus.load_pls = 0;
        bus.ans_vld = 0; bus.is_correct = 0; bus.time_out = 0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.phase != 5) chk("ctrl_sig", int'(bus.ctrl_sig), e.ctrl);
                chk("log_out", int'(bus.log_out), e.log_out);
                chk("score", int'(bus.score), e.score);
                chk("strikes", int'(bus.strikes), e.strikes);
                chk("lett_num", int'(bus.lett_num), e.lett);
                if (e.phase == 1 || e.phase == 4) chk("mode_disp", int'(bus.mode_disp), e.mdisp);
                chk("scram_pls", int'(bus.scram_pls), e.scram);
                chk("flip_pls", int'(bus.flip_pls), e.flip);
                chk("idx_out1", int'(bus.idx_out1), e.idx1);
                chk("idx_out2", int'(bus.idx_out2), e.idx2);
                chk("timer_en", int'(bus.timer_en), e.ten);
                if (e.phase <= 1) chk("timer_reconfig", int'(bus.timer_reconfig), e.trc);
                chk("best_score", int'(bus.best_score), e.best);
                chk("new_best", int'(bus.new_best), e.nb);
                chk("pid_out", int'(bus.pid_out), e.pid);
                chk("is_guest_out", int'(bus.is_guest_out), e.guest);
            end
        end
    end

    initial begin : stimulus
        bus.log_on = 0; bus.pwd_pls = 0; bus.start_pls = 0; bus.load_pls = 0;
        bus.ans_vld = 0; bus.is_correct = 0; bus.time_out = 0;
        bus.pid_in = 3'd5; bus.is_guest_in = 0; bus.idx_in1 = 0; bus.idx_in2 = 0;

        rst = 0;
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;

        // Mode walk to the leaderboard and paging
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 1, 0, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);

        // Mode 1: five correct then time out
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);

        // Strike-out in mode 0
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 1, 1, 0);
        repeat (3) drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);

        // Guest scoring 9 in mode 1 must not touch the record
        bus.is_guest_in = 1;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (9) drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        bus.is_guest_in = 0;

        // Saturation, then a last correct answer together with time_out
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (130) drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 1);
        drive(0, 0, 1, 0, 0, 0, 0);

        // Scrambler pulses, then reset mid-game
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        bus.idx_in1 = 3'd3; bus.idx_in2 = 3'd5;
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;

        // Logout
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

        // Randomised sessions
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            bus.pid_in      = 3'($urandom_range(0, 7));
            bus.is_guest_in = ($urandom_range(0, 3) == 0);
            bus.idx_in1     = 3'($urandom_range(0, 7));
            bus.idx_in2     = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 29) == 0);
        end
        rst = 1;
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
